// File: rtl/parking_gate_arbiter.sv
// Shared barrier-gate arbiter for one entry and one exit lane with occupancy tracking.
// Optional statistics counters are enabled by defining PARKING_GATE_ARB_STATS_EN.
module parking_gate_arbiter #(
  parameter int unsigned CAPACITY       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CLOSE_CYCLES   = 50
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             entry_req,
  input  logic                             exit_req,
  input  logic                             car_passed,
  output logic                             gate_open,
  output logic                             entry_grant,
  output logic                             exit_grant,
  output logic [$clog2(CAPACITY+1)-1:0]    occupancy,
  output logic                             full,
  output logic                             timeout
`ifdef PARKING_GATE_ARB_STATS_EN
  ,
  output logic [7:0]                       denied_count,
  output logic [7:0]                       timeout_count
`endif
);

  localparam int unsigned OCC_W = $clog2(CAPACITY + 1);
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned CD_W  = (CLOSE_CYCLES > 1) ? $clog2(CLOSE_CYCLES) : 1;

  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(CAPACITY);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CD_W-1:0]  CD_LAST = CD_W'(CLOSE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    OPEN_ENTRY = 2'd1,
    OPEN_EXIT  = 2'd2,
    COOLDOWN   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [OCC_W-1:0] occ_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CD_W-1:0]  cd_cnt_q, cd_cnt_d;
  logic             last_exit_q, last_exit_d;
  logic             timeout_d;
  logic             entry_ok, exit_ok;

  assign full     = (occupancy == OCC_MAX);
  assign entry_ok = entry_req && (occupancy < OCC_MAX);
  assign exit_ok  = exit_req && (occupancy != '0);

  // State, counters and decoded gate outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      occupancy   <= '0;
      to_cnt_q    <= '0;
      cd_cnt_q    <= '0;
      last_exit_q <= 1'b1;
      gate_open   <= 1'b0;
      entry_grant <= 1'b0;
      exit_grant  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_q     <= state_d;
      occupancy   <= occ_d;
      to_cnt_q    <= to_cnt_d;
      cd_cnt_q    <= cd_cnt_d;
      last_exit_q <= last_exit_d;
      gate_open   <= (state_d == OPEN_ENTRY) || (state_d == OPEN_EXIT);
      entry_grant <= (state_d == OPEN_ENTRY);
      exit_grant  <= (state_d == OPEN_EXIT);
      timeout     <= timeout_d;
    end
  end

  // Next-state: round-robin grant, passage/timeout close, fixed cooldown
  always_comb begin
    state_d     = state_q;
    occ_d       = occupancy;
    to_cnt_d    = to_cnt_q;
    cd_cnt_d    = cd_cnt_q;
    last_exit_d = last_exit_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (entry_ok && (!exit_ok || last_exit_q)) begin
          state_d     = OPEN_ENTRY;
          last_exit_d = 1'b0;
        end else if (exit_ok) begin
          state_d     = OPEN_EXIT;
          last_exit_d = 1'b1;
        end
      end
      OPEN_ENTRY, OPEN_EXIT: begin
        if (car_passed) begin
          occ_d    = (state_q == OPEN_ENTRY) ? occupancy + OCC_W'(1)
                                             : occupancy - OCC_W'(1);
          state_d  = COOLDOWN;
          cd_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = COOLDOWN;
          cd_cnt_d  = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      COOLDOWN: begin
        if (cd_cnt_q == CD_LAST) begin
          state_d = IDLE;
        end else begin
          cd_cnt_d = cd_cnt_q + CD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PARKING_GATE_ARB_STATS_EN
  logic deny_cond, deny_prev_q;
  assign deny_cond = (state_q == IDLE) && entry_req && full;

  // Saturating counters; denials count once per held request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deny_prev_q   <= 1'b0;
      denied_count  <= '0;
      timeout_count <= '0;
    end else begin
      deny_prev_q <= deny_cond;
      if (deny_cond && !deny_prev_q && (denied_count != 8'hFF)) begin
        denied_count <= denied_count + 8'd1;
      end
      if (timeout_d && (timeout_count != 8'hFF)) begin
        timeout_count <= timeout_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed self-checking bench for parking_gate_arbiter (CAPACITY=3, TIMEOUT=8, CLOSE=2).
module tb_parking_gate_arbiter;

  localparam int unsigned CAP = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_req;
  logic       exit_req;
  logic       car_passed;
  logic       gate_open;
  logic       entry_grant;
  logic       exit_grant;
  logic [1:0] occupancy;
  logic       full;
  logic       timeout;
`ifdef PARKING_GATE_ARB_STATS_EN
  logic [7:0] denied_count;
  logic [7:0] timeout_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parking_gate_arbiter #(
    .CAPACITY      (CAP),
    .TIMEOUT_CYCLES(8),
    .CLOSE_CYCLES  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .entry_req    (entry_req),
    .exit_req     (exit_req),
    .car_passed   (car_passed),
    .gate_open    (gate_open),
    .entry_grant  (entry_grant),
    .exit_grant   (exit_grant),
    .occupancy    (occupancy),
    .full         (full),
    .timeout      (timeout)
`ifdef PARKING_GATE_ARB_STATS_EN
    ,
    .denied_count (denied_count),
    .timeout_count(timeout_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pass_car();
    car_passed = 1'b1;
    tick();
    car_passed = 1'b0;
  endtask

  // Two cooldown cycles with the gate held closed
  task automatic cool();
    repeat (2) begin
      tick();
      check("cool_gate", 32'(gate_open), 32'd0);
    end
  endtask

  // Simple granted entry or exit with immediate passage
  task automatic do_entry();
    entry_req = 1'b1;
    tick();
    check("do_entry_grant", 32'(entry_grant), 32'd1);
    entry_req = 1'b0;
    pass_car();
    cool();
  endtask

  task automatic do_exit();
    exit_req = 1'b1;
    tick();
    check("do_exit_grant", 32'(exit_grant), 32'd1);
    exit_req = 1'b0;
    pass_car();
    cool();
  endtask

  initial begin
    reset      = 1'b0;
    entry_req  = 1'b0;
    exit_req   = 1'b0;
    car_passed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gate", 32'(gate_open), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    @(negedge clk) reset = 1'b1;
    tick();
    check("idle_gate", 32'(gate_open), 32'd0);
    check("idle_eg", 32'(entry_grant), 32'd0);
    check("idle_xg", 32'(exit_grant), 32'd0);
    check("idle_full", 32'(full), 32'd0);
    check("idle_to", 32'(timeout), 32'd0);

    // Single entry with passage three cycles after the grant
    entry_req = 1'b1;
    tick();
    check("e1_grant", 32'(entry_grant), 32'd1);
    check("e1_gate", 32'(gate_open), 32'd1);
    entry_req = 1'b0;
    tick();
    check("e1_gate_c2", 32'(gate_open), 32'd1);
    tick();
    check("e1_gate_c3", 32'(gate_open), 32'd1);
    car_passed = 1'b1;
    tick();
    car_passed = 1'b0;
    check("e1_closed", 32'(gate_open), 32'd0);
    check("e1_eg_low", 32'(entry_grant), 32'd0);
    check("e1_occ", 32'(occupancy), 32'd1);
    entry_req = 1'b1;
    tick();
    check("cd_hold_1", 32'(gate_open), 32'd0);
    tick();
    check("cd_hold_2", 32'(gate_open), 32'd0);
    tick();
    check("after_cd_grant", 32'(entry_grant), 32'd1);
    entry_req = 1'b0;
    pass_car();
    check("e2_occ", 32'(occupancy), 32'd2);
    cool();

    // Fill to capacity, then a held entry request is never granted
    do_entry();
    check("e3_occ", 32'(occupancy), 32'd3);
    check("e3_full", 32'(full), 32'd1);
    entry_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("full_no_gate", 32'(gate_open), 32'd0);
    end
    entry_req = 1'b0;
`ifdef PARKING_GATE_ARB_STATS_EN
    check("denied_cnt", 32'(denied_count), 32'd1);
`endif
    tick();

    // Round-robin: drain to 1, then both requests held
    do_exit();
    check("x1_occ", 32'(occupancy), 32'd2);
    check("x1_full", 32'(full), 32'd0);
    do_exit();
    check("x2_occ", 32'(occupancy), 32'd1);
    entry_req = 1'b1;
    exit_req  = 1'b1;
    tick();
    check("rr1_eg", 32'(entry_grant), 32'd1);
    check("rr1_xg", 32'(exit_grant), 32'd0);
    pass_car();
    check("rr1_occ", 32'(occupancy), 32'd2);
    cool();
    tick();
    check("rr2_xg", 32'(exit_grant), 32'd1);
    check("rr2_eg", 32'(entry_grant), 32'd0);
    pass_car();
    check("rr2_occ", 32'(occupancy), 32'd1);
    entry_req = 1'b0;
    exit_req  = 1'b0;
    cool();

    // Timeout after exactly eight open cycles; withdrawal ignored
    entry_req = 1'b1;
    tick();
    check("to_grant", 32'(entry_grant), 32'd1);
    entry_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to_open", 32'(gate_open), 32'd1);
      check("to_nopulse", 32'(timeout), 32'd0);
    end
    tick();
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_closed", 32'(gate_open), 32'd0);
    check("to_occ", 32'(occupancy), 32'd1);
    tick();
    check("to_pulse_end", 32'(timeout), 32'd0);
`ifdef PARKING_GATE_ARB_STATS_EN
    check("timeout_cnt", 32'(timeout_count), 32'd1);
`endif
    tick();

    // Stray passage pulses in IDLE and COOLDOWN
    pass_car();
    check("idle_pulse_occ", 32'(occupancy), 32'd1);
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    pass_car();
    check("e4_occ", 32'(occupancy), 32'd2);
    pass_car();
    check("cd_pulse_occ", 32'(occupancy), 32'd2);
    tick();
    do_exit();
    do_exit();
    check("empty_occ", 32'(occupancy), 32'd0);
    exit_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("empty_no_gate", 32'(gate_open), 32'd0);
    end
    exit_req = 1'b0;
    tick();

    // Asynchronous reset during an open grant
    do_entry();
    do_entry();
    check("pre_rst_occ", 32'(occupancy), 32'd2);
    entry_req = 1'b1;
    tick();
    check("pre_rst_gate", 32'(gate_open), 32'd1);
    entry_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async_gate", 32'(gate_open), 32'd0);
    check("async_eg", 32'(entry_grant), 32'd0);
    check("async_occ", 32'(occupancy), 32'd0);
    @(negedge clk) reset = 1'b1;
    tick();
    entry_req = 1'b1;
    tick();
    check("post_rst_grant", 32'(entry_grant), 32'd1);
    entry_req = 1'b0;
    pass_car();
    check("post_rst_occ", 32'(occupancy), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
